dcache_read_port_arbiter: RTL and testbench
===========================================

// Module: dcache_read_port_arbiter
// PURPOSE
//  Shares the DCACHE_LSU_READ_PORT_NUM DCache read ports among REQ_NUM requesters: load pipes, replay-queue reissue and prefetch.
//  Sits between MemoryExecutionStage/ReplayQueue and the DCache read interface (dcReadReq/dcReadAddr/dcReadUncachable/dcReadActiveListPtr).
//  Round-robin arbitration with starvation escalation, busy-port skipping and single-outstanding uncachable serialization.
// PARAMETERS
//  REQ_NUM       3                         requesters; index 0..REQ_NUM-1
//  PORT_NUM      DCACHE_LSU_READ_PORT_NUM  DCache read ports (default 2)
//  STARVE_LIMIT  7                         wait cycles before a requester is escalated; counter width $clog2(STARVE_LIMIT+1)
// PORTS
//  clk           in   1               clock
//  rst           in   1               async reset, ACTIVE-LOW (asserted when 0)
//  req           in   [REQ_NUM]       request valid; held until granted or dropped
//  reqAddr       in   PhyAddrPath     per-requester physical address
//  reqUncachable in   [REQ_NUM]       request targets uncachable space
//  reqAlPtr      in   ActiveListIndexPath  per-requester active-list pointer
//  portBusy      in   [PORT_NUM]      port cannot accept this cycle (dcReadBusy)
//  uncDone       in   1               outstanding uncachable access completed this cycle
//  flush         in   1               recovery; suppress all grants this cycle
//  grant         out  [REQ_NUM]       request accepted this cycle
//  grantPort     out  [REQ_NUM] x $clog2(PORT_NUM)  port assigned to granted requester; 0 when not granted
//  portReq       out  [PORT_NUM]      drives dcReadReq
//  portAddr      out  PhyAddrPath     drives dcReadAddr
//  portUnc       out  [PORT_NUM]      drives dcReadUncachable
//  portAlPtr     out  ActiveListIndexPath  drives dcReadActiveListPtr
// BEHAVIOUR
//  - Registered state: rrPtr (index), waitCnt[REQ_NUM], uncInFlight. Reset (rst=0): all 0. Outputs forced 0 while rst=0.
//  - Arbitration is combinational in the request cycle: zero latency from req to grant/portReq.
//  - eligible[i] = req[i] & ~flush & ~(reqUncachable[i] & uncInFlight & ~uncDone).
//  - Priority order: starving requesters (waitCnt==STARVE_LIMIT) in ascending index, then remaining eligible ones
//    circularly from rrPtr (wrap REQ_NUM-1 -> 0). No requester appears twice.
//  - freePorts = ~portBusy in ascending order; k-th winner gets k-th free port; winners = min(#eligible, #freePorts).
//  - At most one uncachable grant per cycle; later uncachable candidates in priority order are skipped, not counted.
//  - Non-granted ports: portReq=0, portAddr/portUnc/portAlPtr=0.
//  - rrPtr <= (highest-priority-order last winner index + 1) mod REQ_NUM on any grant; unchanged if none or flush.
//  - waitCnt[i]: 0 if ~req[i] or grant[i] or flush; else saturating +1 up to STARVE_LIMIT.
//  - uncInFlight: set on uncachable grant; cleared on uncDone; uncDone and a new uncachable grant in the same
//    cycle -> stays 1 (new access outstanding). flush does NOT clear uncInFlight (access in flight still completes).
//  - All ports busy: no grants, waitCnt increments, rrPtr holds.
//  - Reset mid-operation: state cleared asynchronously; any in-flight uncachable is considered abandoned.
//  - Assertions: grant[i] -> req[i]; popcount(grant) <= popcount(~portBusy); no port assigned twice;
//    uncDone only when uncInFlight.
// STRUCTURE
//  - LoadStoreUnitTypes gets DCacheReadArbReqIndexPath, DCacheReadArbPortIndexPath, DCACHE_READ_ARB_REQ_NUM,
//    DCACHE_READ_ARB_STARVE_LIMIT.
//  - Sub-module circular_priority_picker: picks first set bit of a vector starting from a pointer with wrap,
//    instantiated iteratively (masked) PORT_NUM times; rest is flat in this file.
// TESTING
//  - Reset: rst=0 with req=3'b111 -> grant=0, portReq=0; after release rrPtr=0, first grant = {0,1} on ports {0,1}.
//  - Round-robin: req=3'b111 held, no busy -> grants {0,1},{2,0},{1,2} over three cycles; rrPtr 2,1,0.
//  - Busy skip: portBusy=2'b01, req=3'b011, rrPtr=0 -> grant=3'b001, grantPort[0]=1, portReq=2'b10.
//  - Starvation: portBusy=2'b10 and req1 held while req0 re-asserted each cycle with rrPtr forced to favor 0
//    -> by cycle 8 waitCnt[1]=7 and req1 wins over req0.
//  - Uncachable: req0,req1 uncachable same cycle -> only req0 granted, uncInFlight=1; req1 blocked until uncDone,
//    granted in the uncDone cycle, uncInFlight remains 1.
//  - Flush: flush=1 with req=3'b111 -> grant=0, waitCnt cleared, rrPtr and uncInFlight unchanged.

Source files
------------

// File: rtl/dcache_read_port_arbiter_pkg.sv
// Shared widths and index types for the DCache read-port arbiter and its users.
package dcache_read_port_arbiter_pkg;

  localparam int unsigned PHY_ADDR_WIDTH               = 40;
  localparam int unsigned ACTIVE_LIST_INDEX_BIT_WIDTH  = 6;
  localparam int unsigned DCACHE_LSU_READ_PORT_NUM     = 2;
  localparam int unsigned DCACHE_READ_ARB_REQ_NUM      = 3;
  localparam int unsigned DCACHE_READ_ARB_STARVE_LIMIT = 7;

  typedef logic [PHY_ADDR_WIDTH-1:0]                        PhyAddrPath;
  typedef logic [ACTIVE_LIST_INDEX_BIT_WIDTH-1:0]           ActiveListIndexPath;
  typedef logic [$clog2(DCACHE_READ_ARB_REQ_NUM)-1:0]       DCacheReadArbReqIndexPath;
  typedef logic [$clog2(DCACHE_LSU_READ_PORT_NUM)-1:0]      DCacheReadArbPortIndexPath;
  typedef logic [$clog2(DCACHE_READ_ARB_STARVE_LIMIT+1)-1:0] DCacheReadArbWaitCountPath;

endpackage

// File: rtl/dcache_read_port_arbiter_circular_priority_picker.sv
// Finds the first set bit of vec, scanning upward from ptr and wrapping to bit 0.
module circular_priority_picker #(
  parameter int unsigned WIDTH = 3,
  localparam int unsigned IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  int unsigned pos;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned n = 0; n < WIDTH; n++) begin
      pos = (32'(ptr) + n) % WIDTH;
      if (!valid && vec[pos]) begin
        valid = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/dcache_read_port_arbiter.sv
// Round-robin DCache read-port arbiter with starvation escalation, busy-port
// skipping and a single outstanding uncachable access.
module dcache_read_port_arbiter
  import dcache_read_port_arbiter_pkg::*;
#(
  parameter int unsigned REQ_NUM      = DCACHE_READ_ARB_REQ_NUM,
  parameter int unsigned PORT_NUM     = DCACHE_LSU_READ_PORT_NUM,
  parameter int unsigned STARVE_LIMIT = DCACHE_READ_ARB_STARVE_LIMIT,
  localparam int unsigned RIW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  localparam int unsigned PIW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1,
  localparam int unsigned CW  = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REQ_NUM-1:0]  req,
  input  PhyAddrPath          reqAddr [REQ_NUM],
  input  logic [REQ_NUM-1:0]  reqUncachable,
  input  ActiveListIndexPath  reqAlPtr [REQ_NUM],
  input  logic [PORT_NUM-1:0] portBusy,
  input  logic                uncDone,
  input  logic                flush,
  output logic [REQ_NUM-1:0]  grant,
  output logic [PIW-1:0]      grantPort [REQ_NUM],
  output logic [PORT_NUM-1:0] portReq,
  output PhyAddrPath          portAddr [PORT_NUM],
  output logic [PORT_NUM-1:0] portUnc,
  output ActiveListIndexPath  portAlPtr [PORT_NUM]
);

  logic [RIW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  wait_cnt_q [REQ_NUM];
  logic [CW-1:0]  wait_cnt_d [REQ_NUM];
  logic           unc_in_flight_q, unc_in_flight_d;

  logic [REQ_NUM-1:0] eligible, starving;
  logic [PIW-1:0]     free_port [PORT_NUM];
  logic               slot_has_port [PORT_NUM];
  logic               slot_valid [PORT_NUM];
  logic [RIW-1:0]     slot_idx [PORT_NUM];
  logic               any_grant, unc_grant;
  logic [RIW-1:0]     last_winner;
  int unsigned        n_free;

  always_comb begin
    eligible = '0;
    starving = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      eligible[i] = req[i] & ~flush & ~(reqUncachable[i] & unc_in_flight_q & ~uncDone);
      starving[i] = eligible[i] && (wait_cnt_q[i] == CW'(STARVE_LIMIT));
    end
  end

  always_comb begin
    n_free = 0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      free_port[p]     = '0;
      slot_has_port[p] = 1'b0;
    end
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      if (!portBusy[p]) begin
        free_port[n_free]     = PIW'(p);
        slot_has_port[n_free] = 1'b1;
        n_free++;
      end
    end
  end

  // Each slot removes its winner from the candidate set; an uncachable winner
  // also removes every other uncachable candidate so later slots skip them.
  for (genvar k = 0; k < PORT_NUM; k++) begin : g_slot
    logic [REQ_NUM-1:0] cand, cand_out;
    logic               s_valid, n_valid;
    logic [RIW-1:0]     s_idx, n_idx, pick;

    if (k == 0) begin : g_first
      assign cand = eligible;
    end else begin : g_next
      assign cand = g_slot[k-1].cand_out;
    end

    circular_priority_picker #(.WIDTH(REQ_NUM)) u_starve_pick (
      .vec(cand & starving), .ptr('0), .valid(s_valid), .idx(s_idx)
    );
    circular_priority_picker #(.WIDTH(REQ_NUM)) u_rr_pick (
      .vec(cand), .ptr(rr_ptr_q), .valid(n_valid), .idx(n_idx)
    );

    assign pick          = s_valid ? s_idx : n_idx;
    assign slot_valid[k] = n_valid & slot_has_port[k];
    assign slot_idx[k]   = pick;

    always_comb begin
      cand_out       = cand;
      cand_out[pick] = 1'b0;
      if (reqUncachable[pick]) cand_out = cand_out & ~reqUncachable;
    end
  end

  always_comb begin
    grant       = '0;
    portReq     = '0;
    portUnc     = '0;
    any_grant   = 1'b0;
    unc_grant   = 1'b0;
    last_winner = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) grantPort[i] = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      portAddr[p]  = '0;
      portAlPtr[p] = '0;
    end
    if (rst) begin
      for (int unsigned k = 0; k < PORT_NUM; k++) begin
        if (slot_valid[k]) begin
          grant[slot_idx[k]]       = 1'b1;
          grantPort[slot_idx[k]]   = free_port[k];
          portReq[free_port[k]]    = 1'b1;
          portAddr[free_port[k]]   = reqAddr[slot_idx[k]];
          portUnc[free_port[k]]    = reqUncachable[slot_idx[k]];
          portAlPtr[free_port[k]]  = reqAlPtr[slot_idx[k]];
          unc_grant                = unc_grant | reqUncachable[slot_idx[k]];
          any_grant                = 1'b1;
          last_winner              = slot_idx[k];
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (last_winner == RIW'(REQ_NUM - 1)) ? '0 : last_winner + 1'b1;
    end
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (!req[i] || grant[i] || flush) begin
        wait_cnt_d[i] = '0;
      end else if (wait_cnt_q[i] != CW'(STARVE_LIMIT)) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
      end else begin
        wait_cnt_d[i] = wait_cnt_q[i];
      end
    end
    unc_in_flight_d = unc_grant | (unc_in_flight_q & ~uncDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q        <= '0;
      unc_in_flight_q <= 1'b0;
      for (int unsigned i = 0; i < REQ_NUM; i++) wait_cnt_q[i] <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      unc_in_flight_q <= unc_in_flight_d;
      for (int unsigned i = 0; i < REQ_NUM; i++) wait_cnt_q[i] <= wait_cnt_d[i];
    end
  end

  a_grant_has_req: assert property (@(posedge clk) disable iff (!rst) (grant & ~req) == '0);
  a_grant_le_free: assert property (@(posedge clk) disable iff (!rst)
                                    $countones(grant) <= $countones(~portBusy));
  a_port_unique:   assert property (@(posedge clk) disable iff (!rst)
                                    $countones(portReq) == $countones(grant));
  a_unc_done_ok:   assert property (@(posedge clk) disable iff (!rst) uncDone |-> unc_in_flight_q);

endmodule

// File: tb/tb_dcache_read_port_arbiter.sv
// Directed-vector bench for dcache_read_port_arbiter with hand-computed expectations.
module tb_dcache_read_port_arbiter;
  import dcache_read_port_arbiter_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [2:0]         req = '0;
  PhyAddrPath         reqAddr [3];
  logic [2:0]         reqUncachable = '0;
  ActiveListIndexPath reqAlPtr [3];
  logic [1:0]         portBusy = '0;
  logic               uncDone = 1'b0;
  logic               flush = 1'b0;
  logic [2:0]         grant;
  logic [0:0]         grantPort [3];
  logic [1:0]         portReq;
  PhyAddrPath         portAddr [2];
  logic [1:0]         portUnc;
  ActiveListIndexPath portAlPtr [2];

  int vectors = 0;
  int miscompares = 0;

  dcache_read_port_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .reqAddr(reqAddr), .reqUncachable(reqUncachable),
    .reqAlPtr(reqAlPtr), .portBusy(portBusy), .uncDone(uncDone), .flush(flush),
    .grant(grant), .grantPort(grantPort), .portReq(portReq), .portAddr(portAddr),
    .portUnc(portUnc), .portAlPtr(portAlPtr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic [2:0] rq, input logic [2:0] uc, input logic [1:0] bz,
                       input logic dn, input logic fl);
    @(negedge clk);
    req = rq; reqUncachable = uc; portBusy = bz; uncDone = dn; flush = fl;
    #1;
  endtask

  initial begin
    reqAddr[0] = 40'h00_1000_0000; reqAlPtr[0] = 6'd5;
    reqAddr[1] = 40'h00_2000_0040; reqAlPtr[1] = 6'd17;
    reqAddr[2] = 40'h00_3000_0080; reqAlPtr[2] = 6'd42;

    drive(3'b111, 3'b000, 2'b00, 1'b0, 1'b0);
    chk("rst_grant", grant, 3'b000);
    chk("rst_portreq", portReq, 2'b00);
    req = '0;
    rst = 1'b1;

    drive(3'b111, 3'b000, 2'b00, 1'b0, 1'b0);
    chk("rr1_grant", grant, 3'b011);
    chk("rr1_portreq", portReq, 2'b11);
    chk("rr1_gp0", grantPort[0], 1'b0);
    chk("rr1_gp1", grantPort[1], 1'b1);
    chk("rr1_addr1", portAddr[1], 40'h00_2000_0040);
    chk("rr1_alptr0", portAlPtr[0], 6'd5);
    drive(3'b111, 3'b000, 2'b00, 1'b0, 1'b0);
    chk("rr2_grant", grant, 3'b101);
    chk("rr2_gp2", grantPort[2], 1'b0);
    chk("rr2_gp0", grantPort[0], 1'b1);
    chk("rr2_addr0", portAddr[0], 40'h00_3000_0080);
    drive(3'b111, 3'b000, 2'b00, 1'b0, 1'b0);
    chk("rr3_grant", grant, 3'b110);
    chk("rr3_gp1", grantPort[1], 1'b0);
    chk("rr3_gp2", grantPort[2], 1'b1);

    drive(3'b011, 3'b000, 2'b01, 1'b0, 1'b0);
    chk("busy_grant", grant, 3'b001);
    chk("busy_gp0", grantPort[0], 1'b1);
    chk("busy_portreq", portReq, 2'b10);
    chk("busy_addr1", portAddr[1], 40'h00_1000_0000);
    chk("busy_addr0_zero", portAddr[0], 40'h0);

    drive(3'b111, 3'b000, 2'b11, 1'b0, 1'b0);
    chk("allbusy_grant", grant, 3'b000);
    drive(3'b111, 3'b000, 2'b00, 1'b0, 1'b1);
    chk("flush_grant", grant, 3'b000);
    chk("flush_portreq", portReq, 2'b00);
    drive(3'b111, 3'b000, 2'b00, 1'b0, 1'b0);
    chk("rrhold_grant", grant, 3'b110);
    chk("rrhold_gp2", grantPort[2], 1'b1);
    drive(3'b000, 3'b000, 2'b00, 1'b0, 1'b0);
    chk("idle_grant", grant, 3'b000);

    drive(3'b011, 3'b011, 2'b00, 1'b0, 1'b0);
    chk("unc_one_grant", grant, 3'b001);
    chk("unc_one_portunc", portUnc, 2'b01);
    chk("unc_one_portreq", portReq, 2'b01);
    drive(3'b010, 3'b010, 2'b00, 1'b0, 1'b0);
    chk("unc_blocked", grant, 3'b000);
    drive(3'b010, 3'b010, 2'b00, 1'b1, 1'b0);
    chk("unc_done_grant", grant, 3'b010);
    chk("unc_done_portunc", portUnc, 2'b01);
    drive(3'b001, 3'b001, 2'b00, 1'b0, 1'b0);
    chk("unc_still_inflight", grant, 3'b000);

    for (int c = 0; c < 3; c++) begin
      drive(3'b110, 3'b010, 2'b10, 1'b0, 1'b0);
      chk("short_wait_grant", grant, 3'b100);
    end
    drive(3'b011, 3'b010, 2'b10, 1'b1, 1'b0);
    chk("no_escalate_grant", grant, 3'b001);
    chk("no_escalate_portunc", portUnc, 2'b00);
    drive(3'b001, 3'b001, 2'b00, 1'b0, 1'b0);
    chk("unc_cleared_grant", grant, 3'b001);

    for (int c = 0; c < 7; c++) begin
      drive(3'b110, 3'b010, 2'b10, 1'b0, 1'b0);
      chk("starve_wait_grant", grant, 3'b100);
    end
    drive(3'b011, 3'b010, 2'b10, 1'b1, 1'b0);
    chk("escalate_grant", grant, 3'b010);
    chk("escalate_gp1", grantPort[1], 1'b0);
    chk("escalate_portunc", portUnc, 2'b01);
    chk("escalate_addr0", portAddr[0], 40'h00_2000_0040);
    chk("escalate_alptr0", portAlPtr[0], 6'd17);
    drive(3'b001, 3'b001, 2'b00, 1'b0, 1'b0);
    chk("esc_unc_kept", grant, 3'b000);
    drive(3'b001, 3'b001, 2'b00, 1'b1, 1'b0);
    chk("esc_unc_done", grant, 3'b001);

    drive(3'b111, 3'b000, 2'b00, 1'b0, 1'b1);
    chk("flush2_grant", grant, 3'b000);
    drive(3'b001, 3'b001, 2'b00, 1'b0, 1'b0);
    chk("flush_keeps_unc", grant, 3'b000);
    drive(3'b111, 3'b000, 2'b00, 1'b0, 1'b0);
    chk("flush_keeps_rr", grant, 3'b110);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_grant", grant, 3'b000);
    chk("midrst_portreq", portReq, 2'b00);
    req = '0;
    rst = 1'b1;
    drive(3'b001, 3'b001, 2'b00, 1'b0, 1'b0);
    chk("postrst_unc_grant", grant, 3'b001);
    chk("postrst_portunc", portUnc, 2'b01);
    drive(3'b000, 3'b000, 2'b00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
